// File: rtl/led_activity.sv
// led_activity: event pulses to LED activity with shared blink phase; LED_ACTIVITY_DIM_EN adds global PWM dimming
module led_activity #(
  parameter int LEDS             = 4,
  parameter int HALF_PERIOD      = 2083333,
  parameter int TEST_HALF_PERIOD = 8,
  parameter int STRETCH          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEDS-1:0]   triggers,
  input  logic [2*LEDS-1:0] mode,
  input  logic              test_mode,
`ifdef LED_ACTIVITY_DIM_EN
  input  logic [3:0]        dim,
`endif
  output logic              active,
  output logic [LEDS-1:0]   out
);
  localparam int MAXP = HALF_PERIOD > TEST_HALF_PERIOD ? HALF_PERIOD : TEST_HALF_PERIOD;
  localparam int TW   = MAXP > 1 ? $clog2(MAXP) : 1;
  logic [TW-1:0] timer, timer_n;
  logic [LEDS-1:0] pending, pending_n, blink, out_n, lit;
  logic [LEDS-1:0][3:0] cnt, cnt_n;
  logic tick, rise, active_n;
`ifdef LED_ACTIVITY_DIM_EN
  logic [3:0] pwm, pwm_n;
`endif
  // phase timer, pending capture, stretch counting and mode selection from next-state values
  always_comb begin
    tick     = timer == '0;
    rise     = tick & ~active;
    active_n = active ^ tick;
    timer_n  = tick ? (test_mode ? TW'(TEST_HALF_PERIOD - 1) : TW'(HALF_PERIOD - 1)) : timer - TW'(1);
    for (int i = 0; i < LEDS; i++) begin
      pending_n[i] = rise ? triggers[i] : pending[i] | triggers[i];
      cnt_n[i]     = !rise ? cnt[i] : pending[i] ? 4'(STRETCH) : cnt[i] - 4'(cnt[i] != 4'd0);
      blink[i]     = active_n & (cnt_n[i] != 4'd0);
      lit[i]       = mode[2*i+1] ? mode[2*i] ^ blink[i] : mode[2*i];
    end
`ifdef LED_ACTIVITY_DIM_EN
    pwm_n = pwm + 4'd1;
    out_n = lit & {LEDS{pwm_n <= dim}};
`else
    out_n = lit;
`endif
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      out     <= '0;
      pending <= '0;
      cnt     <= '0;
      timer   <= TW'(TEST_HALF_PERIOD - 1);
    end else begin
      active  <= active_n;
      out     <= out_n;
      pending <= pending_n;
      cnt     <= cnt_n;
      timer   <= timer_n;
    end
  end
`ifdef LED_ACTIVITY_DIM_EN
  // free-running brightness PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 4'd0;
    else        pwm <= pwm_n;
  end
`endif
endmodule

// File: tb/tb_led_activity.sv
// tb_led_activity: randomized and directed check of led_activity against a window-level model
module tb_led_activity;
  localparam int L = 4;
  logic clk = 0, rst_n = 0, test_mode = 1;
  logic [L-1:0] triggers = '0;
  logic [2*L-1:0] mode = '0;
  logic act1, act3;
  logic [L-1:0] out1, out3;
`ifdef LED_ACTIVITY_DIM_EN
  logic [3:0] dim = 4'd15;
`endif
  int vec = 0, bad = 0, k = 0;
  int rem [2][L];
  bit pend [2][L];
  int st [2] = '{1, 3};

  always #5 clk = ~clk;

  led_activity #(.LEDS(L), .HALF_PERIOD(20), .TEST_HALF_PERIOD(8), .STRETCH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .triggers(triggers), .mode(mode), .test_mode(test_mode),
`ifdef LED_ACTIVITY_DIM_EN
    .dim(dim),
`endif
    .active(act1), .out(out1));
  led_activity #(.LEDS(L), .HALF_PERIOD(20), .TEST_HALF_PERIOD(8), .STRETCH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .triggers(triggers), .mode(mode), .test_mode(test_mode),
`ifdef LED_ACTIVITY_DIM_EN
    .dim(dim),
`endif
    .active(act3), .out(out3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic model_clear();
    k = 0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < L; i++) begin rem[d][i] = 0; pend[d][i] = 0; end
  endtask

  function automatic logic [L-1:0] exp_out(input int d);
    logic [L-1:0] r;
    bit b;
    for (int i = 0; i < L; i++) begin
      b = ((k / 8) % 2 == 1) && rem[d][i] > 0;
      case (mode[2*i+:2])
        2'b00: r[i] = 1'b0;
        2'b01: r[i] = 1'b1;
        2'b10: r[i] = b;
        default: r[i] = !b;
      endcase
`ifdef LED_ACTIVITY_DIM_EN
      if ((k % 16) > int'(dim)) r[i] = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    k++;
    for (int d = 0; d < 2; d++) for (int i = 0; i < L; i++) begin
      if (k % 16 == 8) begin
        if (pend[d][i]) rem[d][i] = st[d];
        else if (rem[d][i] > 0) rem[d][i]--;
        pend[d][i] = triggers[i];
      end else if (triggers[i]) pend[d][i] = 1;
    end
    #1;
    check("active_s1", 32'(act1), 32'((k / 8) % 2));
    check("active_s3", 32'(act3), 32'((k / 8) % 2));
    check("out_s1", 32'(out1), 32'(exp_out(0)));
    check("out_s3", 32'(out3), 32'(exp_out(1)));
  endtask

  initial begin
    model_clear();
    #12;
    check("reset_active", 32'(act1), 32'd0);
    check("reset_out", 32'(out1), 32'd0);
    @(negedge clk) rst_n = 1;
    mode = 8'hAA;
    triggers = 4'b0001; cyc(); triggers = '0;
    repeat (60) cyc();
    triggers = 4'b0010; repeat (48) cyc(); triggers = '0;
    repeat (60) cyc();
    triggers = 4'b1000; cyc(); triggers = '0;
    repeat (24) cyc();
    triggers = 4'b1000; cyc(); triggers = '0;
    repeat (100) cyc();
    for (int m = 0; m < 3; m++) begin
      mode[5:4] = m == 0 ? 2'b10 : 2'b11;
      triggers = 4'b0100; cyc(); triggers = '0;
      while ((k + 1) % 16 != 8) cyc();
      triggers = 4'b0100; cyc(); triggers = '0;
      repeat (20) cyc();
      if (m == 2) mode[5:4] = 2'b01;
      repeat (30) cyc();
    end
`ifdef LED_ACTIVITY_DIM_EN
    mode = 8'h55; dim = 4'd3; repeat (32) cyc();
    dim = 4'd15; repeat (32) cyc();
`endif
    mode = 8'hAA;
    repeat (600) begin
      triggers = ($urandom % 4 == 0) ? L'($urandom) : '0;
      if ($urandom % 40 == 0) mode = 8'($urandom);
`ifdef LED_ACTIVITY_DIM_EN
      if ($urandom % 60 == 0) dim = 4'($urandom);
`endif
      cyc();
    end
    mode = 8'hAA; triggers = 4'b0001;
`ifdef LED_ACTIVITY_DIM_EN
    dim = 4'd15;
`endif
    while (!((k / 8) % 2 == 1 && k % 8 == 3)) cyc();
    #2 rst_n = 0;
    #1;
    model_clear();
    check("async_active", 32'(act1), 32'd0);
    check("async_out_s1", 32'(out1), 32'd0);
    check("async_out_s3", 32'(out3), 32'd0);
    @(negedge clk) rst_n = 1;
    repeat (40) cyc();
    triggers = '0;
    repeat (300) begin
      triggers = ($urandom % 6 == 0) ? L'($urandom) : '0;
      if ($urandom % 50 == 0) mode = 8'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
